pwm_deadtime: RTL
=================

Name: pwm_deadtime

Overview:
Downstream stage of the PWM peripheral; consumes the single-ended pwm_out of the top-level PWM block and drives a complementary high-side/low-side pair with programmable dead time on each edge. Guarantees both outputs are never high together, and swallows input pulses shorter than the programmed dead time. Runs on the peripheral clock; pwm_in is synchronous to clk, so no synchroniser is needed.

Parameters:
DT_W, 8, width of dead-time counters and dead_rise/dead_fall inputs

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous active-low reset
en  input  1  stage enable; 0 forces both outputs low
pwm_in  input  1  PWM waveform from the PWM generator
dead_rise  input  DT_W  clk cycles both outputs stay low between out_l falling and out_h rising
dead_fall  input  DT_W  clk cycles both outputs stay low between out_h falling and out_l rising
out_h  output  1  high-side drive, registered
out_l  output  1  low-side drive, registered
busy  output  1  1 while a dead-time interval is being counted, registered

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). On reset: state OFF, out_h=0, out_l=0, busy=0, cnt=0.
- States: OFF, LOW_ON, DT_RISE, HIGH_ON, DT_FALL. All outputs are registered from next-state decode, so outputs change on the same edge as the state.
  - OFF: out_h=0, out_l=0.
  - LOW_ON: out_l=1.
  - HIGH_ON: out_h=1.
  - DT_RISE, DT_FALL: out_h=0, out_l=0, busy=1.
- en=0 (any state): OFF at next edge. Any in-progress count is discarded.
- Leaving OFF (en=1):
  - pwm_in=0 -> LOW_ON.
  - pwm_in=1 -> DT_RISE, cnt<=dead_rise. This is a safe start: out_h never rises without a dead interval after OFF, unless dead_rise=0, in which case go directly to HIGH_ON.
- LOW_ON, pwm_in=1:
  - dead_rise!=0 -> DT_RISE, cnt<=dead_rise.
  - dead_rise=0 -> HIGH_ON directly; out_l falls and out_h rises on the same edge.
- DT_RISE:
  - pwm_in=0 -> LOW_ON at next edge (abort; pulse swallowed, out_h never asserted).
  - Else if cnt==1 -> HIGH_ON.
  - Else cnt<=cnt-1.
- HIGH_ON, pwm_in=0: mirror of LOW_ON, using dead_fall and DT_FALL.
- DT_FALL:
  - pwm_in=1 -> HIGH_ON at next edge (abort).
  - Else if cnt==1 -> LOW_ON.
  - Else decrement.
- Timing: if pwm_in rises and is sampled at edge N, out_l=0 after edge N and out_h=1 after edge N+D, where D=dead_rise. Both outputs are low for exactly D cycles (D>=1). Falling edge is symmetric with dead_fall.
- dead_rise/dead_fall are sampled only on entry to a DT state; changes during a count have no effect until the next transition.
- Maximum dead time is 2^DT_W-1 cycles. cnt never wraps: it is only decremented while >1.
- Invariant: out_h & out_l == 0 in every cycle, including reset release and en toggles.
- busy is 1 exactly in DT_RISE/DT_FALL cycles.

Test Plan:
1. Reset, en=1, pwm_in=0, dead_rise=3 -> out_l=1 one cycle after reset release; out_h=0; busy=0.
2. From LOW_ON, pwm_in rises at edge N, dead_rise=3 -> out_l=0 after N; busy=1 for 3 cycles; out_h=1 after N+3. Then pwm_in falls, dead_fall=5 -> out_h=0 immediately, out_l=1 after 5 cycles.
3. dead_rise=4, 2-cycle high pulse on pwm_in -> out_h stays 0 throughout; out_l returns to 1 on the edge after pwm_in falls; busy high for 2 cycles.
4. dead_rise=0, dead_fall=0 -> out_h is exactly pwm_in delayed by 1 cycle, and out_l is its inverse; busy is never 1.
5. en drops mid DT_RISE (cnt=2) -> both outputs 0 and busy=0 next edge. en re-asserted with pwm_in=1, dead_rise=2 -> full 2-cycle dead time before out_h=1.
6. Change dead_rise 3->7 mid count; assert rst_n=0 asynchronously while out_h=1 -> the count completes at the old value 3; on reset, outputs go 0 without waiting for a clk edge. Checker asserts out_h&out_l never 1 over 10k random pwm_in/dead cycles.

Source files
------------

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side driver with programmable dead time on each edge.
// Both outputs are registered from the next-state decode and are never high together.
module pwm_deadtime #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_rise,
  input  logic [DT_W-1:0] dead_fall,
  output logic            out_h,
  output logic            out_l,
  output logic            busy
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LOW_ON  = 3'd1,
    DT_RISE = 3'd2,
    HIGH_ON = 3'd3,
    DT_FALL = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            out_h_d, out_l_d, busy_d;

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      out_h   <= 1'b0;
      out_l   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_h   <= out_h_d;
      out_l   <= out_l_d;
      busy    <= busy_d;
    end
  end

  // Next-state and output decode; counter only decrements while above one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_h_d = 1'b0;
    out_l_d = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      OFF, LOW_ON: begin
        if (pwm_in) begin
          if (dead_rise != '0) begin
            state_d = DT_RISE;
            cnt_d   = dead_rise;
          end else begin
            state_d = HIGH_ON;
          end
        end else begin
          state_d = LOW_ON;
        end
      end
      DT_RISE: begin
        if (!pwm_in) begin
          state_d = LOW_ON;
        end else if (cnt_q == DT_W'(1)) begin
          state_d = HIGH_ON;
        end else begin
          cnt_d = cnt_q - DT_W'(1);
        end
      end
      HIGH_ON: begin
        if (!pwm_in) begin
          if (dead_fall != '0) begin
            state_d = DT_FALL;
            cnt_d   = dead_fall;
          end else begin
            state_d = LOW_ON;
          end
        end
      end
      DT_FALL: begin
        if (pwm_in) begin
          state_d = HIGH_ON;
        end else if (cnt_q == DT_W'(1)) begin
          state_d = LOW_ON;
        end else begin
          cnt_d = cnt_q - DT_W'(1);
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase

    // Disable overrides everything and discards any count in progress
    if (!en) begin
      state_d = OFF;
      cnt_d   = '0;
    end

    out_h_d = (state_d == HIGH_ON);
    out_l_d = (state_d == LOW_ON);
    busy_d  = (state_d == DT_RISE) || (state_d == DT_FALL);
  end

endmodule
